// File: rtl/mac_feeder.sv
`timescale 1ns/1ps
// mac_feeder
// Streams N_PAIRS pixel/weight operand pairs from two synchronous-read
// memories into an external 3-stage MAC (input regs, product reg,
// accumulator), drains the MAC pipeline and captures the dot product.
//
// Optional feature: define MAC_FEEDER_BIAS_EN to add a 16-bit unsigned bias
// input that is latched on start and added to the captured result.
//
// Ports
//   clk, aclr          clock, asynchronous active-high reset
//   start              one-cycle request, only honoured in IDLE
//   weight_base        first weight address, latched on accepted start
//   bias               (MAC_FEEDER_BIAS_EN only) result offset, latched on start
//   pix_addr/pix_rdata pixel memory address / read data (1-cycle latency)
//   w_addr/w_rdata     weight memory address / read data (1-cycle latency)
//   mac_dataa/datab    MAC operands (zero whenever not carrying real data)
//   mac_clken          MAC clock enable
//   mac_aclr           registered one-cycle MAC clear pulse
//   mac_result         MAC accumulator output
//   busy, done         operation in progress / one-cycle completion pulse
//   result             captured dot product, held until the next done
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start
// CLEAR   | mac_aclr high, index cleared, base latched
// PRIME   | first address issued, no operand valid yet
// STREAM  | N_PAIRS cycles of valid operands (addresses run one cycle ahead)
// FLUSH   | 2 cycles of zero operands draining product and accumulator
// CAPTURE | result <= mac_result (+ bias), done high
module mac_feeder #(
  parameter int N_PAIRS = 784,
  parameter int WADDR_W = 14
) (
  input  logic               clk,
  input  logic               aclr,
  input  logic               start,
  input  logic [WADDR_W-1:0] weight_base,
`ifdef MAC_FEEDER_BIAS_EN
  input  logic [15:0]        bias,
`endif
  output logic [9:0]         pix_addr,
  input  logic [7:0]         pix_rdata,
  output logic [WADDR_W-1:0] w_addr,
  input  logic [7:0]         w_rdata,
  output logic [7:0]         mac_dataa,
  output logic [7:0]         mac_datab,
  output logic               mac_clken,
  output logic               mac_aclr,
  input  logic [16:0]        mac_result,
  output logic               busy,
  output logic               done,
  output logic [17:0]        result
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_PRIME   = 3'd2;
  localparam logic [2:0] S_STREAM  = 3'd3;
  localparam logic [2:0] S_FLUSH   = 3'd4;
  localparam logic [2:0] S_CAPTURE = 3'd5;

  localparam logic [9:0] IDX_END  = 10'(N_PAIRS);
  localparam logic [9:0] LAST_CNT = 10'(N_PAIRS - 1);

  logic [2:0]         state;
  logic [9:0]         index;
  logic [9:0]         cnt;
  logic [WADDR_W-1:0] base_q;
  logic               valid;
  logic               issue;
`ifdef MAC_FEEDER_BIAS_EN
  logic [15:0]        bias_q;
`endif

  // Addresses go out in PRIME and the first N_PAIRS-1 STREAM cycles, so the
  // read data (and the valid flag) line up exactly with the STREAM cycles.
  assign issue = ((state == S_PRIME) || (state == S_STREAM)) && (index != IDX_END);

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state    <= S_IDLE;
      index    <= '0;
      cnt      <= '0;
      base_q   <= '0;
      valid    <= 1'b0;
      mac_aclr <= 1'b0;
      result   <= '0;
`ifdef MAC_FEEDER_BIAS_EN
      bias_q   <= '0;
`endif
    end else begin
      mac_aclr <= 1'b0;
      valid    <= issue;
      if (issue) index <= index + 10'd1;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_CLEAR;
            index    <= '0;
            base_q   <= weight_base;
            mac_aclr <= 1'b1;
`ifdef MAC_FEEDER_BIAS_EN
            bias_q   <= bias;
`endif
          end
        end
        S_CLEAR: state <= S_PRIME;
        S_PRIME: begin
          state <= S_STREAM;
          cnt   <= LAST_CNT;
        end
        S_STREAM: begin
          if (cnt == 10'd0) begin
            state <= S_FLUSH;
            cnt   <= 10'd1;
          end else begin
            cnt <= cnt - 10'd1;
          end
        end
        S_FLUSH: begin
          if (cnt == 10'd0) state <= S_CAPTURE;
          else              cnt   <= cnt - 10'd1;
        end
        S_CAPTURE: begin
          state <= S_IDLE;
`ifdef MAC_FEEDER_BIAS_EN
          result <= {1'b0, mac_result} + {2'b00, bias_q};
`else
          result <= {1'b0, mac_result};
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pix_addr  = index;
  assign w_addr    = base_q + WADDR_W'(index);
  assign mac_dataa = valid ? pix_rdata : 8'd0;
  assign mac_datab = valid ? w_rdata : 8'd0;
  assign mac_clken = valid || (state == S_FLUSH);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_CAPTURE);

endmodule
